// File: rtl/mult_arbiter.sv
// mult_arbiter: two-port valid/ready arbiter and multicycle sequencer for a
// shared combinational multiplier. Operands are held on mul_rs/mul_rd for LAT
// cycles, the truncated product is captured into res_q and held until the
// owning requester accepts it.
// Optional feature: define MULT_ARB_RR_EN for round-robin arbitration;
// otherwise requester 0 has fixed priority.
module mult_arbiter #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LAT   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_rs,
    input  logic [WIDTH-1:0] req0_rd,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_rs,
    input  logic [WIDTH-1:0] req1_rd,
    output logic             req1_ready,
    output logic             res0_valid,
    input  logic             res0_ready,
    output logic             res1_valid,
    input  logic             res1_ready,
    output logic [WIDTH-1:0] res_q,
    output logic [WIDTH-1:0] mul_rs,
    output logic [WIDTH-1:0] mul_rd,
    input  logic [WIDTH-1:0] mul_q,
    output logic             busy
);

    // LAT is limited to 1..15, so LAT-1 fits in four bits
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               owner_q, owner_d;
    logic [WIDTH-1:0]   mul_rs_q, mul_rs_d;
    logic [WIDTH-1:0]   mul_rd_q, mul_rd_d;
    logic [WIDTH-1:0]   res_val_q, res_val_d;
    logic               res0_valid_q, res0_valid_d;
    logic               res1_valid_q, res1_valid_d;
    logic               busy_q, busy_d;
    logic               grant0, grant1;

`ifdef MULT_ARB_RR_EN
    // last_q remembers the most recently accepted requester (1 after reset)
    logic               last_q, last_d;

    // Round-robin grant: on contention the requester not granted last wins
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_q);
        grant1 = req1_valid && (!req0_valid || !last_q);
    end
`else
    // Fixed-priority grant: requester 0 always wins contention
    always_comb begin
        grant0 = req0_valid;
        grant1 = req1_valid && !req0_valid;
    end
`endif

    // Next-state, datapath next values and combinational ready
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        mul_rs_d   = mul_rs_q;
        mul_rd_d   = mul_rd_q;
        res_val_d  = res_val_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
`ifdef MULT_ARB_RR_EN
        last_d     = last_q;
`endif
        case (state_q)
            IDLE: begin
                req0_ready = grant0 && !rst;
                req1_ready = grant1 && !rst;
                if (grant0 || grant1) begin
                    owner_d  = grant1;
                    mul_rs_d = grant1 ? req1_rs : req0_rs;
                    mul_rd_d = grant1 ? req1_rd : req0_rd;
                    cnt_d    = CNT_W'(LAT - 1);
                    state_d  = CALC;
`ifdef MULT_ARB_RR_EN
                    last_d   = grant1;
`endif
                end
            end
            CALC: begin
                if (cnt_q == '0) begin
                    res_val_d = mul_q;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (owner_q ? res1_ready : res0_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        res0_valid_d = (state_d == DONE) && !owner_d;
        res1_valid_d = (state_d == DONE) && owner_d;
        busy_d       = (state_d != IDLE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            owner_q      <= 1'b0;
            mul_rs_q     <= '0;
            mul_rd_q     <= '0;
            res_val_q    <= '0;
            res0_valid_q <= 1'b0;
            res1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef MULT_ARB_RR_EN
            last_q       <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            mul_rs_q     <= mul_rs_d;
            mul_rd_q     <= mul_rd_d;
            res_val_q    <= res_val_d;
            res0_valid_q <= res0_valid_d;
            res1_valid_q <= res1_valid_d;
            busy_q       <= busy_d;
`ifdef MULT_ARB_RR_EN
            last_q       <= last_d;
`endif
        end
    end

    assign res_q      = res_val_q;
    assign mul_rs     = mul_rs_q;
    assign mul_rd     = mul_rd_q;
    assign res0_valid = res0_valid_q;
    assign res1_valid = res1_valid_q;
    assign busy       = busy_q;

endmodule
